// File: rtl/task_graph_sequencer_if.sv
// task_graph_sequencer_if: task stream from sequencer to mapper (valid/ready, weight, row, col, root flag)
interface task_graph_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2
);
    logic              task_valid;
    logic              task_ready;
    logic [DATA_W-1:0] task_array;
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic              root_task;
    modport master (output task_valid, task_array, row, col, root_task, input task_ready);
    modport slave  (input task_valid, task_array, row, col, root_task, output task_ready);
endinterface

// File: rtl/task_graph_sequencer.sv
// task_graph_sequencer: streams a stored NUM_V x NUM_V weight matrix row-major to the mapper, num_apps times; ports: clk, rst, cfg_we/cfg_addr/cfg_wdata, start/num_apps, tk stream, app_end, app_count, busy, done
module task_graph_sequencer #(
    parameter int NUM_V  = 4,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2,
    parameter int APP_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [2*IDX_W-1:0]   cfg_addr,
    input  logic [DATA_W-1:0]    cfg_wdata,
    input  logic                 start,
    input  logic [APP_W-1:0]     num_apps,
    task_graph_sequencer_if.master tk,
    output logic                 app_end,
    output logic [APP_W-1:0]     app_count,
    output logic                 busy,
    output logic                 done
);
    localparam int AW = 2*IDX_W;
    typedef enum logic [2:0] {IDLE, ISSUE, GAP, APP_END, APP_GAP, DONE} state_t;
    state_t state, next_state;
    logic [DATA_W-1:0] mem [NUM_V*NUM_V];
    logic [IDX_W-1:0] row_q, col_q;
    logic [APP_W-1:0] apps;
    logic root_seen;
    logic [AW-1:0] idx;
    logic [DATA_W-1:0] weight;
    logic last, wrap, root_hit;
    assign idx      = AW'(row_q) * AW'(NUM_V) + AW'(col_q);
    assign weight   = mem[idx];
    assign wrap     = col_q == IDX_W'(NUM_V-1);
    assign last     = wrap && row_q == IDX_W'(NUM_V-1);
    assign root_hit = state == ISSUE && !root_seen && weight != '0;
    assign tk.task_valid = state == ISSUE;
    assign tk.task_array = state == ISSUE ? weight : '0;
    assign tk.row        = row_q;
    assign tk.col        = col_q;
    assign tk.root_task  = root_hit;
    assign app_end = state == APP_END;
    assign busy    = state != IDLE;
    assign done    = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end
    // The final application goes straight from APP_END to DONE so that done lands N*(2*NUM_V^2+2) cycles after start.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? (num_apps == '0 ? DONE : ISSUE) : IDLE;
            ISSUE:   next_state = tk.task_ready ? GAP : ISSUE;
            GAP:     next_state = last ? APP_END : ISSUE;
            APP_END: next_state = APP_W'(app_count + 1'b1) == apps ? DONE : APP_GAP;
            APP_GAP: next_state = ISSUE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_V*NUM_V; i++) mem[i] <= '0;
            row_q     <= '0;
            col_q     <= '0;
            root_seen <= 1'b0;
            apps      <= '0;
            app_count <= '0;
        end else begin
            if (state == IDLE && cfg_we) mem[cfg_addr] <= cfg_wdata;
            if (state == IDLE && start) begin
                apps      <= num_apps;
                app_count <= '0;
                row_q     <= '0;
                col_q     <= '0;
                root_seen <= 1'b0;
            end
            if (tk.task_ready && root_hit) root_seen <= 1'b1;
            if (state == GAP && !last) begin
                col_q <= wrap ? '0 : col_q + 1'b1;
                row_q <= wrap ? row_q + 1'b1 : row_q;
            end
            if (state == APP_END) begin
                app_count <= app_count + 1'b1;
                row_q     <= '0;
                col_q     <= '0;
                root_seen <= 1'b0;
            end
        end
    end
endmodule
